ram_prog: RTL and testbench

Parametrised single-port RAM for the SAP-2 mini datapath, successor to the fixed 256x12 program RAM. It adds a handshaked program loader with an auto-incrementing pointer and a hardware fill (clear) sequencer. It also adds registered reads with defined latency. It sits between the bus/control sequencer (run-mode port) and the front-panel or host loader (program-mode port).

---
 rtl/sap2_pkg.sv | 19 +
 rtl/ram_prog_if.sv | 43 ++++
 rtl/ram_prog_core.sv | 38 +++
 rtl/ram_prog.sv | 149 ++++++++++++++
 tb/tb_ram_prog.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sap2_pkg.sv
// ---------------------------------------------------------------------------
// sap2_pkg
// Shared definitions for the SAP-2 mini datapath.
//   state_t      : ram_prog controller states (2-bit encoding)
//   SAP2_DATA_W  : default word width shared with the SAP-2 mini top
//   SAP2_ADDR_W  : default address width shared with the SAP-2 mini top
// ---------------------------------------------------------------------------
package sap2_pkg;

   localparam int SAP2_DATA_W = 12;
   localparam int SAP2_ADDR_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

endpackage

// File: rtl/ram_prog_if.sv
// ---------------------------------------------------------------------------
// ram_prog_if
// Bundles the run-mode bus, the program loader and the clear controls of
// ram_prog.
//   master : bus sequencer / loader side (drives requests, reads status)
//   slave  : ram_prog side
// Loader handshake: a word on ld_data is transferred on every rising clock
// edge where ld_valid and ld_ready are both high; ld_valid may be raised or
// dropped freely, and ld_ready is only high while in LOAD with prog high.
// state is a debug view of the controller FSM.
// ---------------------------------------------------------------------------
interface ram_prog_if #(
   parameter int DATA_W = sap2_pkg::SAP2_DATA_W,
   parameter int ADDR_W = sap2_pkg::SAP2_ADDR_W
) ();

   logic              prog;
   logic              ce;
   logic              we;
   logic [ADDR_W-1:0] a;
   logic [DATA_W-1:0] d;
   logic [DATA_W-1:0] out;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_ptr;
   logic              ld_wrap;
   logic              clr;
   logic              busy;
   logic              done;
   sap2_pkg::state_t  state;

   modport master (
      output prog, ce, we, a, d, ld_valid, ld_data, clr,
      input  out, ld_ready, ld_ptr, ld_wrap, busy, done, state
   );

   modport slave (
      input  prog, ce, we, a, d, ld_valid, ld_data, clr,
      output out, ld_ready, ld_ptr, ld_wrap, busy, done, state
   );

endinterface

// File: rtl/ram_prog_core.sv
// ---------------------------------------------------------------------------
// ram_core
// Synchronous single-port array with one write port and a registered read.
//   clk, rst : clock, async active-high reset (read register only)
//   we/wa/wd : write enable, address, data
//   re/ra    : read enable, address
//   q        : registered read data; 0 on any cycle without a read
// The array itself is not reset.
// ---------------------------------------------------------------------------
module ram_core #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              re,
   input  logic [ADDR_W-1:0] ra,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   // Reads and writes never share a cycle, so a read on the cycle after a
   // write already sees the updated word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (re) q <= mem[ra];
      else         q <= '0;
   end

endmodule

// File: rtl/ram_prog.sv
// ---------------------------------------------------------------------------
// ram_prog
// Parametrised program RAM with a handshaked auto-incrementing loader and a
// hardware fill sequencer.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset (RAM contents are kept)
//   bus  : ram_prog_if.slave - run-mode port (ce/we/a/d/out), loader
//          (prog/ld_valid/ld_data/ld_ready/ld_ptr/ld_wrap), clear
//          (clr/busy/done) and debug state
// Parameters: DATA_W word width, ADDR_W address width (depth 2**ADDR_W),
//             FILL value written by clear.
// ---------------------------------------------------------------------------
module ram_prog
   import sap2_pkg::*;
#(
   parameter int                DATA_W = SAP2_DATA_W,
   parameter int                ADDR_W = SAP2_ADDR_W,
   parameter logic [DATA_W-1:0] FILL   = '0
) (
   input  logic      clk,
   input  logic      rst,
   ram_prog_if.slave bus
);

   // Fill counter is one bit wider so reaching DEPTH marks the end exactly.
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_t            state;
   logic [ADDR_W-1:0] ld_ptr;
   logic              ld_wrap;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_nxt;
   logic              busy;
   logic              done;
   logic              ld_ready;
   logic              ld_acc;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_q;

   // ld_ready falls with prog in the same cycle, so a word offered while
   // leaving LOAD is never taken.
   assign ld_ready = (state == ST_LOAD) && bus.prog;
   assign ld_acc   = ld_ready && bus.ld_valid;
   assign cnt_nxt  = cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ld_ptr  <= '0;
         ld_wrap <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // prog has priority; a simultaneous clr is dropped.
               if (bus.prog) begin
                  state   <= ST_LOAD;
                  ld_ptr  <= '0;
                  ld_wrap <= 1'b0;
               end else if (bus.clr) begin
                  state <= ST_CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (ld_acc) begin
                  ld_ptr <= ld_ptr + 1'b1;
                  if (&ld_ptr) ld_wrap <= 1'b1;
               end
               if (!bus.prog) state <= ST_IDLE;
            end
            ST_CLEAR: begin
               cnt <= cnt_nxt;
               if (cnt_nxt == DEPTH) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Single write port shared by run mode, loader and fill.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!bus.prog && bus.ce) begin
               if (bus.we) begin
                  wr_en   = 1'b1;
                  wr_addr = bus.a;
                  wr_data = bus.d;
               end else begin
                  rd_en = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (ld_acc) begin
               wr_en   = 1'b1;
               wr_addr = ld_ptr;
               wr_data = bus.ld_data;
            end
         end
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = cnt[ADDR_W-1:0];
            wr_data = FILL;
         end
         default: ;
      endcase
   end

   ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk (clk),
      .rst (rst),
      .we  (wr_en),
      .wa  (wr_addr),
      .wd  (wr_data),
      .re  (rd_en),
      .ra  (bus.a),
      .q   (rd_q)
   );

   assign bus.out      = rd_q;
   assign bus.ld_ready = ld_ready;
   assign bus.ld_ptr   = ld_ptr;
   assign bus.ld_wrap  = ld_wrap;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.state    = state;

endmodule

// File: tb/tb_ram_prog.sv
// ---------------------------------------------------------------------------
// tb_ram_prog
// Three ram_prog instances: default (12x256, FILL=0), ADDR_W=2 for pointer
// wrap, ADDR_W=3 with FILL=0xFFF for clear. A select drives the shared
// stimulus into one instance at a time and muxes its outputs back.
// Inputs change just after the falling edge; outputs are sampled at the
// next falling edge.
// ---------------------------------------------------------------------------
module tb_ram_prog;
   import sap2_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic        prog = 1'b0, ce = 1'b0, we = 1'b0, clr = 1'b0, ld_valid = 1'b0;
   logic [7:0]  a = '0;
   logic [11:0] d = '0, ld_data = '0;

   logic [11:0] o_out;
   logic        o_rdy, o_wrap, o_busy, o_done;
   logic [7:0]  o_ptr;
   logic [1:0]  o_state;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [11:0] exp_q[$];
   logic [11:0] rv [4];
   int n_done;

   always #5 clk = ~clk;

   ram_prog_if #(.DATA_W(12), .ADDR_W(8)) b0 ();
   ram_prog_if #(.DATA_W(12), .ADDR_W(2)) b1 ();
   ram_prog_if #(.DATA_W(12), .ADDR_W(3)) b2 ();

   assign b0.prog = prog && sel == 2'd0;
   assign b0.ce = ce && sel == 2'd0;
   assign b0.we = we;
   assign b0.a = a;
   assign b0.d = d;
   assign b0.ld_valid = ld_valid && sel == 2'd0;
   assign b0.ld_data = ld_data;
   assign b0.clr = clr && sel == 2'd0;

   assign b1.prog = prog && sel == 2'd1;
   assign b1.ce = ce && sel == 2'd1;
   assign b1.we = we;
   assign b1.a = a[1:0];
   assign b1.d = d;
   assign b1.ld_valid = ld_valid && sel == 2'd1;
   assign b1.ld_data = ld_data;
   assign b1.clr = clr && sel == 2'd1;

   assign b2.prog = prog && sel == 2'd2;
   assign b2.ce = ce && sel == 2'd2;
   assign b2.we = we;
   assign b2.a = a[2:0];
   assign b2.d = d;
   assign b2.ld_valid = ld_valid && sel == 2'd2;
   assign b2.ld_data = ld_data;
   assign b2.clr = clr && sel == 2'd2;

   ram_prog #(.DATA_W(12), .ADDR_W(8), .FILL(12'h000)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   ram_prog #(.DATA_W(12), .ADDR_W(2), .FILL(12'h000)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   ram_prog #(.DATA_W(12), .ADDR_W(3), .FILL(12'hFFF)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

   always_comb begin
      case (sel)
         2'd1: begin
            o_out = b1.out; o_rdy = b1.ld_ready; o_ptr = 8'(b1.ld_ptr);
            o_wrap = b1.ld_wrap; o_busy = b1.busy; o_done = b1.done; o_state = b1.state;
         end
         2'd2: begin
            o_out = b2.out; o_rdy = b2.ld_ready; o_ptr = 8'(b2.ld_ptr);
            o_wrap = b2.ld_wrap; o_busy = b2.busy; o_done = b2.done; o_state = b2.state;
         end
         default: begin
            o_out = b0.out; o_rdy = b0.ld_ready; o_ptr = b0.ld_ptr;
            o_wrap = b0.ld_wrap; o_busy = b0.busy; o_done = b0.done; o_state = b0.state;
         end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Run-mode write; out must read 0 after a write cycle.
   task automatic wr(input logic [7:0] addr, input logic [11:0] data);
      ce = 1'b1; we = 1'b1; a = addr; d = data;
      cyc();
      ce = 1'b0; we = 1'b0;
      chk("wr_out0", o_out, 12'h000);
   endtask

   // Run-mode read: expectation queued at issue, compared when out appears.
   task automatic rd(input logic [7:0] addr, input logic [11:0] expv);
      ce = 1'b1; we = 1'b0; a = addr;
      exp_q.push_back(expv);
      cyc();
      ce = 1'b0;
      chk($sformatf("rd[%0d]", addr), o_out, exp_q.pop_front());
   endtask

   initial begin
      // ---- async reset, checked before any clock edge ----
      #2 rst = 1'b1;
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #0;
         chk("rst_out", o_out, 12'h000);
         chk("rst_rdy", o_rdy, 1'b0);
         chk("rst_busy", o_busy, 1'b0);
         chk("rst_done", o_done, 1'b0);
         chk("rst_ptr", o_ptr, 8'h00);
         chk("rst_wrap", o_wrap, 1'b0);
         chk("rst_state", o_state, ST_IDLE);
      end
      sel = 2'd0;
      cyc();
      rst = 1'b0;

      // ---- run mode, default instance ----
      wr(8'd3, 12'h5A5);
      rd(8'd3, 12'h5A5);
      wr(8'd4, 12'h123);
      rd(8'd4, 12'h123);
      cyc();
      chk("ce0_out", o_out, 12'h000);
      for (int i = 0; i < 4; i++) begin
         rv[i] = 12'($urandom_range(0, 4095));
         wr(8'(40 + i), rv[i]);
      end
      for (int i = 0; i < 4; i++) rd(8'(40 + i), rv[i]);

      // ---- LOAD with gaps and ignored run-mode writes ----
      wr(8'd5, 12'h055);
      wr(8'd20, 12'h111);
      prog = 1'b1;
      cyc();
      chk("ld_rdy", o_rdy, 1'b1);
      chk("ld_ptr0", o_ptr, 8'd0);
      chk("ld_state", o_state, ST_LOAD);
      for (int i = 1; i <= 5; i++) begin
         ld_valid = 1'b1; ld_data = 12'(i);
         cyc();
         ld_valid = 1'b0;
         chk("ld_ptr", o_ptr, 8'(i));
         if (i % 2 == 1) begin
            ce = 1'b1; we = 1'b1; a = 8'd20; d = 12'hBAD;
            cyc();
            ce = 1'b0; we = 1'b0;
            chk("ld_out0", o_out, 12'h000);
         end
      end
      chk("ld_wrap0", o_wrap, 1'b0);
      prog = 1'b0; ld_valid = 1'b1; ld_data = 12'h999;
      #1;
      chk("ld_rdy_drop", o_rdy, 1'b0);
      cyc();
      ld_valid = 1'b0;
      chk("ld_ptr_hold", o_ptr, 8'd5);
      chk("ld_exit", o_state, ST_IDLE);
      for (int i = 0; i < 5; i++) rd(8'(i), 12'(i + 1));
      rd(8'd5, 12'h055);
      rd(8'd20, 12'h111);

      // ---- pointer wrap, ADDR_W=2 ----
      sel = 2'd1;
      prog = 1'b1;
      cyc();
      for (int i = 0; i < 5; i++) begin
         ld_valid = 1'b1; ld_data = 12'(10 + i);
         cyc();
         if (i == 2) chk("wrap_early", o_wrap, 1'b0);
      end
      ld_valid = 1'b0;
      chk("wrap_set", o_wrap, 1'b1);
      chk("wrap_ptr", o_ptr, 8'd1);
      prog = 1'b0;
      cyc();
      rd(8'd0, 12'd14);
      for (int i = 1; i < 4; i++) rd(8'(i), 12'(10 + i));
      prog = 1'b1;
      cyc();
      chk("wrap_clr", o_wrap, 1'b0);
      prog = 1'b0;
      cyc();

      // ---- prog and clr together: LOAD wins ----
      sel = 2'd2;
      for (int i = 0; i < 8; i++) wr(8'(i), 12'(12'h100 + i));
      prog = 1'b1; clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("pc_state", o_state, ST_LOAD);
      chk("pc_busy", o_busy, 1'b0);
      prog = 1'b0;
      cyc();
      cyc();
      chk("pc_nodone", o_done, 1'b0);
      rd(8'd0, 12'h100);

      // ---- full clear, ADDR_W=3, FILL=0xFFF ----
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_busy", o_busy, 1'b1);
      chk("clr_done0", o_done, 1'b0);
      n_done = 0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 5) begin
            ce = 1'b1; we = 1'b1; a = 8'd1; d = 12'h0AB;
         end
         cyc();
         ce = 1'b0; we = 1'b0;
         if (o_done === 1'b1) n_done++;
         chk($sformatf("clr_busy_%0d", k), o_busy, (k < 8) ? 1'b1 : 1'b0);
         chk("clr_out0", o_out, 12'h000);
      end
      chk("clr_done_end", o_done, 1'b1);
      cyc();
      chk("clr_done_pulse", o_done, 1'b0);
      chk("clr_done_count", n_done, 1);
      for (int i = 0; i < 8; i++) rd(8'(i), 12'hFFF);

      // ---- reset during clear after three fill writes ----
      for (int i = 0; i < 8; i++) wr(8'(i), 12'(12'h200 + i));
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         chk("abort_nodone", o_done, 1'b0);
      end
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", o_busy, 1'b0);
      chk("abort_done", o_done, 1'b0);
      chk("abort_state", o_state, ST_IDLE);
      cyc();
      rst = 1'b0;
      cyc();
      chk("abort_done_after", o_done, 1'b0);
      for (int i = 0; i < 3; i++) rd(8'(i), 12'hFFF);
      for (int i = 3; i < 8; i++) rd(8'(i), 12'(12'h200 + i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
